mem_stage_lsu: RTL and testbench

- Memory stage of the 5-stage 32-bit RISC-V pipeline.
- Consumes the 141-bit EX/MEM pipeline bus and performs data-memory loads/stores over a req/ack handshake, with byte/halfword alignment and sign/zero extension.
- Resolves branch redirect, stalls upstream stages while an access is pending, and registers the 104-bit MEM/WB bus for writeback.

---
 rtl/mem_stage_lsu.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- memory stage of the 5-stage RV32 pipeline.
//
// Takes the EX/MEM bus, performs data-memory loads and stores over a
// req/ack handshake (lane alignment, byte enables, sign/zero extension),
// resolves the branch redirect, stalls the upstream stages while an access
// is outstanding and registers the MEM/WB bus.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ex_mem[140:0]     EX/MEM pipeline bus
//   mem_size[2:0]     funct3 of the instruction in MEM
//   dmem_*            registered data-memory request interface
//   stall             hold PC, IF/ID, ID/EX, EX/MEM
//   pc_redirect/target combinational branch resolution
//   misalign          1-cycle pulse: misaligned access (or timeout abort)
//   mem_wb[103:0]     registered MEM/WB bus
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that is not
// acknowledged within TIMEOUT_CYCLES cycles of WAIT.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [140:0] ex_mem,
  input  logic [2:0]   mem_size,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [31:0]  dmem_wdata,
  output logic [3:0]   dmem_be,
  input  logic         dmem_ack,
  input  logic [31:0]  dmem_rdata,
  output logic         stall,
  output logic         pc_redirect,
  output logic [31:0]  pc_target,
  output logic         misalign,
  output logic [103:0] mem_wb
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Counter must be able to represent TIMEOUT_CYCLES.
  if (TO_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  // EX/MEM field decode
  logic [31:0] pc, pc_alu_sum, alu_result, data2;
  logic [1:0]  result_src, mem_con;
  logic        pc_src, reg_con, branch, zero;
  logic [4:0]  rd;
  assign pc         = ex_mem[140:109];
  assign result_src = ex_mem[108:107];
  assign pc_src     = ex_mem[106];
  assign reg_con    = ex_mem[105];
  assign mem_con    = ex_mem[104:103];
  assign branch     = ex_mem[102];
  assign pc_alu_sum = ex_mem[101:70];
  assign zero       = ex_mem[69];
  assign alu_result = ex_mem[68:37];
  assign data2      = ex_mem[36:5];
  assign rd         = ex_mem[4:0];

  assign pc_redirect = (branch & zero) | pc_src;
  assign pc_target   = pc_alu_sum;

  // Access size: 0 byte, 1 halfword, 2 word (unknown funct3 acts as word).
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = 2'd0;
      3'b001, 3'b101: size_of = 2'd1;
      default:        size_of = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    be_of = 4'b0001 << a;
      2'd1:    be_of = a[1] ? 4'b1100 : 4'b0011;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    wdata_of = {4{d[7:0]}};
      2'd1:    wdata_of = {2{d[15:0]}};
      default: wdata_of = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [103:0] wb_pack(input logic rc, input logic [31:0] ld);
    wb_pack = {pc, result_src, rc, ld, alu_result, rd};
  endfunction

  state_t         state, state_next;
  logic [103:0]   mem_wb_next;
  logic           misalign_next, issue, finish, to_hit, mem_op, misaligned;
  logic [1:0]     size;

  assign mem_op     = (mem_con != 2'b00);
  assign size       = size_of(mem_size);
  assign misaligned = ((size == 2'd1) && alu_result[0]) ||
                      ((size == 2'd2) && (alu_result[1:0] != 2'b00));

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter: counts WAIT cycles, cleared whenever not waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if ((state == WAIT) && !dmem_ack && !to_hit) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next-state, stall and MEM/WB next-value decode.
  always_comb begin
    state_next    = state;
    stall         = 1'b0;
    mem_wb_next   = 104'd0;
    misalign_next = 1'b0;
    issue         = 1'b0;
    finish        = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          mem_wb_next = wb_pack(reg_con, 32'd0);
        end else if (misaligned) begin
          mem_wb_next   = wb_pack(1'b0, 32'd0);
          misalign_next = 1'b1;
        end else begin
          stall      = 1'b1;
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          // Ack wins over a timeout on the same cycle.
          mem_wb_next = wb_pack(reg_con, mem_con[1] ? 32'd0
                                         : load_ext(mem_size, alu_result[1:0], dmem_rdata));
          finish      = 1'b1;
          state_next  = IDLE;
        end else if (to_hit) begin
          mem_wb_next   = wb_pack(1'b0, 32'd0);
          misalign_next = 1'b1;
          finish        = 1'b1;
          state_next    = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, MEM/WB and misalign registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mem_wb   <= 104'd0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      mem_wb   <= mem_wb_next;
      misalign <= misalign_next;
    end
  end

  // Data-memory request registers: loaded on issue, held through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_con[1];
      dmem_addr  <= {alu_result[31:2], 2'b00};
      dmem_wdata <= wdata_of(size, data2);
      dmem_be    <= be_of(size, alu_result[1:0]);
    end else if (finish) begin
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      dmem_be  <= 4'd0;
    end else begin
      dmem_req <= dmem_req;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic         clk = 1'b0;
  logic         rst;
  logic [140:0] ex_mem;
  logic [2:0]   mem_size;
  logic         dmem_req, dmem_we, dmem_ack, stall, pc_redirect, misalign;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata, pc_target;
  logic [3:0]   dmem_be;
  logic [103:0] mem_wb;

  int checks = 0;
  int errors = 0;
  int sc;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .ex_mem(ex_mem), .mem_size(mem_size),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .misalign(misalign), .mem_wb(mem_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [103:0] got, input logic [103:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [140:0] mk(input logic [31:0] pc, input logic [1:0] rs,
      input logic pcsrc, input logic rc, input logic [1:0] mc, input logic br,
      input logic [31:0] sum, input logic z, input logic [31:0] alu,
      input logic [31:0] d2, input logic [4:0] rd);
    return {pc, rs, pcsrc, rc, mc, br, sum, z, alu, d2, rd};
  endfunction

  function automatic logic [103:0] wb(input logic [31:0] pc, input logic [1:0] rs,
      input logic rc, input logic [31:0] ld, input logic [31:0] alu, input logic [4:0] rd);
    return {pc, rs, rc, ld, alu, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // load table: funct3, address, expected be, expected load_data (rdata 0x80AABBCC)
  logic [2:0]  lt_f3 [4] = '{3'b101, 3'b001, 3'b100, 3'b010};
  logic [31:0] lt_a  [4] = '{32'h102, 32'h100, 32'h101, 32'h100};
  logic [3:0]  lt_be [4] = '{4'b1100, 4'b0011, 4'b0010, 4'b1111};
  logic [31:0] lt_ld [4] = '{32'h0000_80AA, 32'hFFFF_BBCC, 32'h0000_00BB, 32'h80AA_BBCC};

  initial begin
    rst = 1'b0; ex_mem = '0; mem_size = 3'b000; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    #2;
    check("rst_mem_wb", mem_wb, 104'd0);
    check("rst_req", dmem_req, 1'b0);
    check("rst_be", dmem_be, 4'd0);
    check("rst_misalign", misalign, 1'b0);
    @(negedge clk); rst = 1'b1;

    // ADD
    ex_mem = mk(32'h1000, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 1'b0, 32'h10, 32'd0, 5'd5);
    #1 check("add_stall", stall, 1'b0);
    tick();
    check("add_mem_wb", mem_wb, wb(32'h1000, 2'b00, 1'b1, 32'd0, 32'h10, 5'd5));

    // LB at 0x103, ack after 3 WAIT cycles
    ex_mem = mk(32'h1004, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 32'd0, 1'b0, 32'h103, 32'd0, 5'd7);
    mem_size = 3'b000;
    #1 sc = int'(stall);
    tick();
    check("lb_req", dmem_req, 1'b1);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_be", dmem_be, 4'b1000);
    check("lb_we", dmem_we, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("lb_bubble", mem_wb, 104'd0);
      sc += int'(stall);
      tick();
    end
    check("lb_req_held", dmem_req, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h80AABBCC;
    #1 check("lb_stall_ack", stall, 1'b0);
    tick();
    dmem_ack = 1'b0;
    ex_mem = '0;
    check("lb_stall_cycles", 104'(sc), 104'd4);
    check("lb_mem_wb", mem_wb, wb(32'h1004, 2'b01, 1'b1, 32'hFFFFFF80, 32'h103, 5'd7));
    check("lb_req_drop", dmem_req, 1'b0);

    // SH at 0x202
    ex_mem = mk(32'h1008, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 1'b0, 32'h202, 32'h1234ABCD, 5'd0);
    mem_size = 3'b001;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("sh_we", dmem_we, 1'b1);
      check("sh_be", dmem_be, 4'b1100);
      check("sh_wdata", dmem_wdata, 32'hABCDABCD);
      check("sh_stall", stall, 1'b1);
      tick();
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    ex_mem = '0;
    check("sh_req_drop", dmem_req, 1'b0);
    check("sh_mem_wb", mem_wb, wb(32'h1008, 2'b00, 1'b0, 32'd0, 32'h202, 5'd0));

    // LW at 0x301: misaligned
    ex_mem = mk(32'h100C, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 32'd0, 1'b0, 32'h301, 32'd0, 5'd9);
    mem_size = 3'b010;
    #1 check("mis_stall", stall, 1'b0);
    tick();
    ex_mem = '0;
    check("mis_req", dmem_req, 1'b0);
    check("mis_pulse", misalign, 1'b1);
    check("mis_mem_wb", mem_wb, wb(32'h100C, 2'b01, 1'b0, 32'd0, 32'h301, 5'd9));
    tick();
    check("mis_pulse_end", misalign, 1'b0);

    // Branch resolution
    ex_mem = mk(32'h0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 32'h400, 1'b1, 32'd0, 32'd0, 5'd0);
    #1 check("br_taken", pc_redirect, 1'b1);
    check("br_target", pc_target, 32'h400);
    ex_mem = mk(32'h0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 32'h400, 1'b0, 32'd0, 32'd0, 5'd0);
    #1 check("br_not_taken", pc_redirect, 1'b0);
    ex_mem = mk(32'h0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 32'h500, 1'b0, 32'd0, 32'd0, 5'd0);
    #1 check("jump", pc_redirect, 1'b1);
    tick();

    // Load variants, ack on first WAIT cycle
    for (int i = 0; i < 4; i++) begin
      ex_mem = mk(32'h2000, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 32'd0, 1'b0, lt_a[i], 32'd0, 5'd3);
      mem_size = lt_f3[i];
      tick();
      check("ld_be", dmem_be, lt_be[i]);
      dmem_ack = 1'b1; dmem_rdata = 32'h80AABBCC;
      tick();
      dmem_ack = 1'b0;
      ex_mem = '0;
      check("ld_data", mem_wb[68:37], lt_ld[i]);
    end

    // Reset during WAIT
    ex_mem = mk(32'h3000, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 32'd0, 1'b0, 32'h40, 32'd0, 5'd4);
    mem_size = 3'b010;
    tick();
    tick();
    check("rw_req_before", dmem_req, 1'b1);
    rst = 1'b0;
    #1 check("rw_req", dmem_req, 1'b0);
    check("rw_mem_wb", mem_wb, 104'd0);
    @(negedge clk); rst = 1'b1; ex_mem = '0;
    tick();
    check("rw_idle", dmem_req, 1'b0);

`ifdef MEM_TIMEOUT_EN
    ex_mem = mk(32'h4000, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 32'd0, 1'b0, 32'h80, 32'd0, 5'd6);
    mem_size = 3'b010;
    tick();
    sc = 0;
    for (int k = 0; k < 15; k++) begin
      sc += int'(stall);
      tick();
    end
    check("to_stall_cycles", 104'(sc), 104'd15);
    check("to_term_stall", stall, 1'b0);
    tick();
    ex_mem = '0;
    check("to_req", dmem_req, 1'b0);
    check("to_pulse", misalign, 1'b1);
    check("to_regcon", mem_wb[69], 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
